// File: rtl/rotation_addr_gen_pkg.sv
// Shared fixed-point widths, FSM states and matrix element select codes
// used by the rotation address generator and its multiply-accumulate lanes.
package rotation_addr_gen_pkg;

    localparam int COEF_W = 33;
    localparam int FRAC_W = 20;
    localparam int PIX_W  = 9;
    localparam int PROD_W = COEF_W + PIX_W;
    localparam int SUM_W  = PROD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam logic [2:0] SEL_M00 = 3'd0;
    localparam logic [2:0] SEL_M01 = 3'd1;
    localparam logic [2:0] SEL_M10 = 3'd2;
    localparam logic [2:0] SEL_M11 = 3'd3;

endpackage

// File: rtl/rotation_addr_gen_if.sv
// Matrix-fetch and pixel-output bus of the rotation address generator;
// master is the generator, slave is the matrix stage plus pixel consumer.
interface rotation_addr_gen_if #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
);
    import rotation_addr_gen_pkg::*;

    localparam int AW = $clog2(IMG_W * IMG_H);

    logic [2:0]                aci_out;
    logic [2:0]                selection;
    logic signed [COEF_W-1:0]  selected_value;
    logic                      out_valid;
    logic                      out_ready;
    logic [AW-1:0]             dst_addr;
    logic signed [PIX_W-1:0]   src_x;
    logic signed [PIX_W-1:0]   src_y;
    logic                      in_bounds;

    modport master (
        output aci_out, selection, out_valid, dst_addr, src_x, src_y, in_bounds,
        input  selected_value, out_ready
    );

    modport slave (
        input  aci_out, selection, out_valid, dst_addr, src_x, src_y, in_bounds,
        output selected_value, out_ready
    );

endinterface

// File: rtl/rotation_addr_gen_rot_mac2.sv
// Two-stage signed dot product a*da + b*db in Q13.20, shifted back to pixels.
// Define ROT_ROUND_EN to round half up before the shift instead of truncating.
module rot_mac2
    import rotation_addr_gen_pkg::*;
#(
    parameter int OFFSET = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic signed [COEF_W-1:0] coef_a,
    input  logic signed [COEF_W-1:0] coef_b,
    input  logic signed [PIX_W-1:0]  op_a,
    input  logic signed [PIX_W-1:0]  op_b,
    output logic signed [PIX_W-1:0]  result
);

`ifdef ROT_ROUND_EN
    localparam logic [SUM_W-1:0] HALF_LSB =
        {{(SUM_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`endif

    logic signed [PROD_W-1:0] prod_a_q, prod_a_d;
    logic signed [PROD_W-1:0] prod_b_q, prod_b_d;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_r;
    logic signed [PIX_W-1:0]  res_q, res_d;

    always_comb begin
        prod_a_d = prod_a_q;
        prod_b_d = prod_b_q;
        res_d    = res_q;
        sum      = SUM_W'(prod_a_q) + SUM_W'(prod_b_q);
`ifdef ROT_ROUND_EN
        sum_r    = sum + HALF_LSB;
`else
        sum_r    = sum;
`endif
        if (en) begin
            prod_a_d = coef_a * op_a;
            prod_b_d = coef_b * op_b;
            // Out-of-range results wrap in two's complement by design.
            res_d    = PIX_W'(sum_r >>> FRAC_W) + PIX_W'(OFFSET);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_a_q <= '0;
            prod_b_q <= '0;
            res_q    <= '0;
        end else begin
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
            res_q    <= res_d;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/rotation_addr_gen.sv
// Raster-scans a destination frame and emits the rotated source coordinate
// per pixel; ROT_ROUND_EN selects round-half-up instead of truncation.
module rotation_addr_gen
    import rotation_addr_gen_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] aci,
    output logic       busy,
    output logic       done,
    rotation_addr_gen_if.master bus
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int AW = XW + YW;

    state_e                   state_q, state_d;
    logic [2:0]               load_cnt_q, load_cnt_d;
    logic [2:0]               selection_q, selection_d;
    logic [2:0]               aci_q, aci_d;
    logic signed [COEF_W-1:0] m00_q, m00_d, m01_q, m01_d;
    logic signed [COEF_W-1:0] m10_q, m10_d, m11_q, m11_d;
    logic [XW-1:0]            x_q, x_d;
    logic [YW-1:0]            y_q, y_d;
    logic                     v1_q, v1_d;
    logic                     out_valid_q, out_valid_d;
    logic                     done_q, done_d;
    logic [AW-1:0]            addr1_q, addr1_d;
    logic [AW-1:0]            dst_addr_q, dst_addr_d;
    logic                     advance;
    logic                     mac_en;
    logic signed [PIX_W-1:0]  dx, dy, src_x, src_y;

    // A stalled output freezes every stage and the scan counter together.
    assign advance = !out_valid_q || bus.out_ready;
    assign mac_en  = advance && (state_q == ST_RUN || state_q == ST_DRAIN);
    assign dx      = PIX_W'(x_q) - PIX_W'(IMG_W / 2);
    assign dy      = PIX_W'(y_q) - PIX_W'(IMG_H / 2);

    rot_mac2 #(.OFFSET(IMG_W / 2)) u_mac_x (
        .clk(clk), .reset(reset), .en(mac_en),
        .coef_a(m00_q), .coef_b(m01_q), .op_a(dx), .op_b(dy), .result(src_x)
    );

    rot_mac2 #(.OFFSET(IMG_H / 2)) u_mac_y (
        .clk(clk), .reset(reset), .en(mac_en),
        .coef_a(m10_q), .coef_b(m11_q), .op_a(dx), .op_b(dy), .result(src_y)
    );

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        selection_d = selection_q;
        aci_d       = aci_q;
        m00_d       = m00_q;
        m01_d       = m01_q;
        m10_d       = m10_q;
        m11_d       = m11_q;
        x_d         = x_q;
        y_d         = y_q;
        v1_d        = v1_q;
        out_valid_d = out_valid_q;
        addr1_d     = addr1_q;
        dst_addr_d  = dst_addr_q;
        done_d      = 1'b0;

        if (advance) begin
            v1_d        = 1'b0;
            out_valid_d = v1_q;
            if (v1_q) begin
                dst_addr_d = addr1_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD;
                    aci_d       = aci;
                    load_cnt_d  = 3'd0;
                    selection_d = SEL_M00;
                    x_d         = '0;
                    y_d         = '0;
                end
            end
            ST_LOAD: begin
                // The matrix stage answers one cycle after each select.
                load_cnt_d = load_cnt_q + 3'd1;
                if (load_cnt_q < 3'd3) begin
                    selection_d = load_cnt_q + 3'd1;
                end
                case (load_cnt_q)
                    3'd1: m00_d = bus.selected_value;
                    3'd2: m01_d = bus.selected_value;
                    3'd3: m10_d = bus.selected_value;
                    3'd4: begin
                        m11_d       = bus.selected_value;
                        selection_d = SEL_M00;
                        state_d     = ST_RUN;
                    end
                    default: ;
                endcase
            end
            ST_RUN: begin
                if (advance) begin
                    v1_d    = 1'b1;
                    addr1_d = {y_q, x_q};
                    if (x_q == XW'(IMG_W - 1)) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                        if (y_q == YW'(IMG_H - 1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid_q && bus.out_ready && !v1_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            load_cnt_q  <= '0;
            selection_q <= '0;
            aci_q       <= '0;
            m00_q       <= '0;
            m01_q       <= '0;
            m10_q       <= '0;
            m11_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            addr1_q     <= '0;
            dst_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            selection_q <= selection_d;
            aci_q       <= aci_d;
            m00_q       <= m00_d;
            m01_q       <= m01_d;
            m10_q       <= m10_d;
            m11_q       <= m11_d;
            x_q         <= x_d;
            y_q         <= y_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            addr1_q     <= addr1_d;
            dst_addr_q  <= dst_addr_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign bus.selection = selection_q;
    assign bus.aci_out   = aci_q;
    assign bus.out_valid = out_valid_q;
    assign bus.dst_addr  = dst_addr_q;
    assign bus.src_x     = src_x;
    assign bus.src_y     = src_y;
    assign bus.in_bounds = out_valid_q
                         && (int'(src_x) >= 0) && (int'(src_x) < IMG_W)
                         && (int'(src_y) >= 0) && (int'(src_y) < IMG_H);

endmodule
